// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared types and constants for the tuning controller
//
// Purpose: FSM state encoding, button index constants, default step and
// limit values, and a small width helper used by the tuner modules.
// Ports: none (package).

package tuner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } tuner_state_t;

  // Button indices; lower index wins when several buttons are held.
  localparam logic [1:0] BTN_UP    = 2'd0;
  localparam logic [1:0] BTN_DOWN  = 2'd1;
  localparam logic [1:0] BTN_RIGHT = 2'd2;
  localparam logic [1:0] BTN_LEFT  = 2'd3;
  localparam int         NUM_BTN   = 4;

  localparam logic [39:0] DEF_INIT_PHASE  = 40'h2656abde3;
  localparam logic [39:0] DEF_FINE_STEP   = 40'h110c6f7;
  localparam logic [39:0] DEF_COARSE_STEP = 40'h1346dc5d;
  localparam logic [39:0] DEF_PHASE_MIN   = 40'h0;
  localparam logic [39:0] DEF_PHASE_MAX   = 40'h7fffffffff;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic btn_is_inc(input logic [1:0] btn);
    return (btn == BTN_UP) || (btn == BTN_RIGHT);
  endfunction

  function automatic logic btn_is_coarse(input logic [1:0] btn);
    return (btn == BTN_UP) || (btn == BTN_DOWN);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus debounce filter for one button
//
// Purpose: brings an asynchronous button into the clock domain and only
// moves the output level after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw button, asynchronous, active-high
//   level  out 1  debounced level

module btn_debounce
  import tuner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Input agrees with the accepted level: any partial run was a bounce.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tuner_ctrl.sv
// rtl/tuner_ctrl.sv - button-driven saturating phase-increment controller
//
// Purpose: turns four front-panel buttons into a registered, clamped NCO
// tuning word with fine/coarse steps, hold-to-repeat and a direct load path.
// Ports:
//   CLK        in  1        system clock
//   RSTb       in  1        asynchronous active-low reset
//   btn_up     in  1        raw button, +COARSE_STEP
//   btn_down   in  1        raw button, -COARSE_STEP
//   btn_left   in  1        raw button, -FINE_STEP
//   btn_right  in  1        raw button, +FINE_STEP
//   load_en    in  1        single-cycle strobe loading load_val
//   load_val   in  PHASE_W  requested tuning word
//   phase_inc  out PHASE_W  registered tuning word
//   phase_upd  out 1        pulse in the cycle phase_inc takes a new value
//   at_limit   out 1        phase_inc sits at PHASE_MIN or PHASE_MAX

module tuner_ctrl
  import tuner_pkg::*;
#(
  parameter int                 PHASE_W         = 40,
  parameter logic [PHASE_W-1:0] INIT_PHASE      = DEF_INIT_PHASE,
  parameter logic [PHASE_W-1:0] FINE_STEP       = DEF_FINE_STEP,
  parameter logic [PHASE_W-1:0] COARSE_STEP     = DEF_COARSE_STEP,
  parameter logic [PHASE_W-1:0] PHASE_MIN       = DEF_PHASE_MIN,
  parameter logic [PHASE_W-1:0] PHASE_MAX       = DEF_PHASE_MAX,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_RATE     = 10000000
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               load_en,
  input  logic [PHASE_W-1:0] load_val,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               phase_upd,
  output logic               at_limit
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = cnt_width(TMAX);

  logic [NUM_BTN-1:0] btn_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(CLK), .rst_n(RSTb), .raw(btn_up), .level(btn_level[BTN_UP])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk(CLK), .rst_n(RSTb), .raw(btn_down), .level(btn_level[BTN_DOWN])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(CLK), .rst_n(RSTb), .raw(btn_right), .level(btn_level[BTN_RIGHT])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(CLK), .rst_n(RSTb), .raw(btn_left), .level(btn_level[BTN_LEFT])
  );

  // Highest-priority held button; later assignments override earlier ones.
  logic [1:0] active_btn;
  always_comb begin
    active_btn = BTN_LEFT;
    if (btn_level[BTN_RIGHT]) active_btn = BTN_RIGHT;
    if (btn_level[BTN_DOWN])  active_btn = BTN_DOWN;
    if (btn_level[BTN_UP])    active_btn = BTN_UP;
  end

  tuner_state_t  state, next_state;
  logic [1:0]    latched_btn, next_btn;
  logic [TW-1:0] timer, next_timer;
  logic          step_en;
  logic [1:0]    step_btn;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state       <= ST_IDLE;
      latched_btn <= BTN_UP;
      timer       <= '0;
    end else begin
      state       <= next_state;
      latched_btn <= next_btn;
      timer       <= next_timer;
    end
  end

  always_comb begin
    next_state = state;
    next_btn   = latched_btn;
    next_timer = timer;
    step_en    = 1'b0;
    step_btn   = latched_btn;
    case (state)
      ST_IDLE: begin
        if (|btn_level) begin
          next_btn   = active_btn;
          step_btn   = active_btn;
          step_en    = 1'b1;
          next_state = ST_DELAY;
          next_timer = '0;
        end
      end
      ST_DELAY: begin
        // Release of the latched button wins even if others are still held.
        if (!btn_level[latched_btn]) begin
          next_state = ST_IDLE;
        end else if (timer == TW'(REPEAT_DELAY - 1)) begin
          step_en    = 1'b1;
          next_state = ST_REPEAT;
          next_timer = '0;
        end else begin
          next_timer = timer + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!btn_level[latched_btn]) begin
          next_state = ST_IDLE;
        end else if (timer == TW'(REPEAT_RATE - 1)) begin
          step_en    = 1'b1;
          next_timer = '0;
        end else begin
          next_timer = timer + TW'(1);
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // One extra bit catches both carry-out on increment and borrow on decrement.
  logic [PHASE_W:0]   step_amt;
  logic [PHASE_W:0]   inc_sum;
  logic [PHASE_W:0]   dec_diff;
  logic [PHASE_W-1:0] stepped;
  logic [PHASE_W-1:0] load_clamped;

  always_comb begin
    step_amt = btn_is_coarse(step_btn) ? {1'b0, COARSE_STEP} : {1'b0, FINE_STEP};
    inc_sum  = {1'b0, phase_inc} + step_amt;
    dec_diff = {1'b0, phase_inc} - step_amt;
    if (btn_is_inc(step_btn)) begin
      stepped = (inc_sum > {1'b0, PHASE_MAX}) ? PHASE_MAX : inc_sum[PHASE_W-1:0];
    end else begin
      stepped = (dec_diff[PHASE_W] || (dec_diff < {1'b0, PHASE_MIN}))
                ? PHASE_MIN : dec_diff[PHASE_W-1:0];
    end
    if (load_val > PHASE_MAX) begin
      load_clamped = PHASE_MAX;
    end else if (load_val < PHASE_MIN) begin
      load_clamped = PHASE_MIN;
    end else begin
      load_clamped = load_val;
    end
  end

  // A load wins over a coincident step; the step is simply dropped.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      phase_inc <= INIT_PHASE;
      phase_upd <= 1'b0;
    end else if (load_en) begin
      phase_inc <= load_clamped;
      phase_upd <= 1'b1;
    end else if (step_en) begin
      phase_inc <= stepped;
      phase_upd <= 1'b1;
    end else begin
      phase_upd <= 1'b0;
    end
  end

  assign at_limit = (phase_inc == PHASE_MIN) || (phase_inc == PHASE_MAX);

endmodule

// File: tb/tb_tuner_ctrl.sv
// tb/tb_tuner_ctrl.sv - self-checking bench for tuner_ctrl
//
// Purpose: drives directed button/load vectors, compares the DUT every
// cycle against a behavioural model and pins the model with literals.
// Ports: none (top-level bench).

module tb_tuner_ctrl;

  localparam int     DEB   = 4;
  localparam int     RD    = 20;
  localparam int     RR    = 8;
  localparam longint INIT  = 64'h2656abde3;
  localparam longint FINE  = 64'h110c6f7;
  localparam longint COARS = 64'h1346dc5d;
  localparam longint PMIN  = 64'h0;
  localparam longint PMAX  = 64'h7fffffffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up, down, left, right;
  logic        load_en;
  logic [39:0] load_val;
  logic [39:0] phase_inc;
  logic        phase_upd;
  logic        at_limit;

  always #5 clk = ~clk;

  tuner_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .CLK(clk), .RSTb(rst_n),
    .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
    .load_en(load_en), .load_val(load_val),
    .phase_inc(phase_inc), .phase_upd(phase_upd), .at_limit(at_limit)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int upd_times[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button vector index: 0 up, 1 down, 2 right, 3 left (0 = highest priority).
  logic [3:0] hist [0:DEB+1];   // raw samples, hist[i] taken i edges ago
  logic [3:0] m_level;
  int         m_held;           // -1 when no button is latched
  int         m_n;              // edges since the initial step of this hold
  longint     m_phase;
  bit         m_upd;

  function automatic longint clampv(input longint v);
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
  endfunction

  function automatic longint delta(input int b);
    case (b)
      0:       return COARS;
      1:       return -COARS;
      2:       return FINE;
      default: return -FINE;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DEB + 1; i++) hist[i] = 4'b0;
      m_level = 4'b0;
      m_held  = -1;
      m_n     = 0;
      m_phase = INIT;
      m_upd   = 1'b0;
    end else begin
      bit step;
      int sel;
      bool_flip_block: begin
        step = 1'b0;
        sel  = 0;
        if (m_held < 0) begin
          if (m_level != 4'b0) begin
            for (int i = 3; i >= 0; i--) if (m_level[i]) sel = i;
            m_held = sel;
            m_n    = 0;
            step   = 1'b1;
          end
        end else if (!m_level[m_held]) begin
          m_held = -1;
        end else begin
          m_n++;
          if (m_n == RD || (m_n > RD && (m_n - RD) % RR == 0)) step = 1'b1;
        end
        if (load_en) begin
          m_phase = clampv(longint'({24'b0, load_val}));
          m_upd   = 1'b1;
        end else if (step) begin
          m_phase = clampv(m_phase + delta(m_held));
          m_upd   = 1'b1;
        end else begin
          m_upd = 1'b0;
        end
        // Synchronized value seen at this edge is the raw sample from two
        // edges back; a level flips once DEB such values in a row disagree.
        for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {left, right, down, up};
        for (int b = 0; b < 4; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 2; j < 2 + DEB; j++)
            if (hist[j][b] == m_level[b]) all_diff = 1'b0;
          if (all_diff) m_level[b] = ~m_level[b];
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_phase_inc", phase_inc, 40'(m_phase));
      check("model_phase_upd", 40'(phase_upd), 40'(m_upd));
      check("model_at_limit", 40'(at_limit), 40'(m_phase == PMIN || m_phase == PMAX));
      if (phase_upd) upd_times.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_btns(input logic [3:0] m);
    up    = m[0];
    down  = m[1];
    right = m[2];
    left  = m[3];
  endtask

  task automatic hold(input logic [3:0] m, input int n);
    set_btns(m);
    repeat (n) @(negedge clk);
    set_btns(4'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    upd_times.delete();
  endtask

  task automatic load(input logic [39:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  initial begin
    int t0;
    rst_n    = 1'b0;
    load_en  = 1'b0;
    load_val = 40'h0;
    set_btns(4'b0);
    idle(3);
    check("reset_async_phase", phase_inc, 40'h2656abde3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_phase", phase_inc, 40'h2656abde3);
    check("reset_upd", 40'(phase_upd), 40'h0);
    check("reset_limit", 40'(at_limit), 40'h0);
    upd_times.delete();

    // Single press: one step, 7 cycles after the press.
    t0 = cyc;
    hold(4'b0100, 10);
    idle(12);
    check("single_upd_count", 40'(upd_times.size()), 40'd1);
    if (upd_times.size() > 0) check("single_latency", 40'(upd_times[0] - t0), 40'd7);
    check("single_phase", phase_inc, 40'h2667b84da);

    // Bounce: up toggling every 2 cycles never settles.
    upd_times.delete();
    for (int i = 0; i < 10; i++) begin
      hold(4'b0001, 2);
      idle(2);
    end
    idle(10);
    check("bounce_no_upd", 40'(upd_times.size()), 40'd0);
    check("bounce_phase", phase_inc, 40'h2667b84da);

    // Hold-repeat on down.
    do_reset();
    t0 = cyc;
    hold(4'b0010, 60);
    idle(12);
    check("repeat_count", 40'(upd_times.size()), 40'd6);
    if (upd_times.size() == 6) begin
      int offs [6] = '{0, 20, 28, 36, 44, 52};
      check("repeat_first_latency", 40'(upd_times[0] - t0), 40'd7);
      for (int i = 1; i < 6; i++)
        check("repeat_spacing", 40'(upd_times[i] - upd_times[0]), 40'(offs[i]));
    end
    check("repeat_phase", phase_inc, 40'h1f1c193b5);

    // Asynchronous reset in the middle of REPEAT.
    do_reset();
    set_btns(4'b0010);
    idle(40);
    #2 rst_n = 1'b0;
    #1;
    check("midrep_reset_phase", phase_inc, 40'h2656abde3);
    check("midrep_reset_upd", 40'(phase_upd), 40'h0);
    check("midrep_reset_limit", 40'(at_limit), 40'h0);
    set_btns(4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    upd_times.delete();

    // Clamp at the top.
    load(40'h7ffff00000);
    check("load_value", phase_inc, 40'h7ffff00000);
    check("load_upd", 40'(phase_upd), 40'h1);
    hold(4'b0001, 10);
    idle(12);
    check("clamp_max_phase", phase_inc, 40'h7fffffffff);
    check("clamp_max_limit", 40'(at_limit), 40'h1);

    // Clamp at the bottom.
    load(40'h100);
    hold(4'b1000, 10);
    idle(12);
    check("clamp_min_phase", phase_inc, 40'h0);
    check("clamp_min_limit", 40'(at_limit), 40'h1);

    // Back-to-back loads, one of them out of range.
    load_en  = 1'b1;
    load_val = 40'h123456789;
    @(negedge clk);
    check("b2b_load1", phase_inc, 40'h123456789);
    load_val = 40'hffffffffff;
    @(negedge clk);
    load_en = 1'b0;
    check("b2b_load2_clamped", phase_inc, 40'h7fffffffff);
    check("b2b_load2_upd", 40'(phase_upd), 40'h1);

    // Priority: up and left together gives only +COARSE.
    do_reset();
    hold(4'b1001, 10);
    idle(12);
    check("prio_upd_count", 40'(upd_times.size()), 40'd1);
    check("prio_phase", phase_inc, 40'h278b19a40);

    // Load coincident with the first step of a right press.
    do_reset();
    set_btns(4'b0100);
    idle(6);
    load(40'h41fc8f323);
    check("load_vs_step_phase", phase_inc, 40'h41fc8f323);
    idle(3);
    set_btns(4'b0);
    idle(12);
    check("load_vs_step_upd_count", 40'(upd_times.size()), 40'd1);
    check("load_vs_step_final", phase_inc, 40'h41fc8f323);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
